// File: rtl/approx_carry_adder_pipe_if.sv
// Valid/ready bundle for the pipelined approximate adder.
// master: operand source + result sink; slave: the adder.
interface approx_carry_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_approx;

  modport master (
    output in_valid, a, b, cin, approx_en,
    output out_ready,
    input  in_ready, out_valid, sum,
    input  cout, out_approx
  );

  modport slave (
    input  in_valid, a, b, cin, approx_en,
    input  out_ready,
    output in_ready, out_valid, sum,
    output cout, out_approx
  );
endinterface

// File: rtl/approx_carry_adder_pipe.sv
// SEGS-stage carry-segmented adder, optional OR-approximate low part.
// Ports: clk, rst (async high), bus (slave): beats in, sums out.
module approx_carry_adder_pipe #(
  parameter int WIDTH       = 32,
  parameter int SEGS        = 4,
  parameter int APPROX_BITS = 8
) (
  input logic clk,
  input logic rst,
  approx_carry_adder_pipe_if.slave bus
);
  localparam int SW = WIDTH / SEGS;

  logic stall;

  // One segment of cells; each bit picks its cell from its index.
  // Below the boundary the chain is cut; only bit K-1 generates.
  function automatic logic [SW:0] seg_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          c,
    input logic          m,
    input int            base
  );
    logic [SW-1:0] s;
    logic          k;
    k = c;
    for (int j = 0; j < SW; j++) begin
      if (m && (base + j) < APPROX_BITS) begin
        s[j] = x[j] | y[j];
        k = ((base + j) == APPROX_BITS - 1) ?
            (x[j] & y[j]) : 1'b0;
      end else begin
        s[j] = x[j] ^ y[j] ^ k;
        k = (x[j] & y[j]) | (k & (x[j] ^ y[j]));
      end
    end
    return {k, s};
  endfunction

  for (genvar s = 0; s < SEGS; s++) begin : g_stage
    logic [SW-1:0]       xa;
    logic [SW-1:0]       xb;
    logic                ci;
    logic                mi;
    logic                vi;
    logic [SW:0]         r;
    logic [(s+1)*SW-1:0] sum_d;
    logic                v_q;
    logic                m_q;
    logic                c_q;
    logic [(s+1)*SW-1:0] sum_q;

    if (s == 0) begin : g_first
      assign xa = bus.a[SW-1:0];
      assign xb = bus.b[SW-1:0];
      assign ci = bus.cin &
                  ~(bus.approx_en && (APPROX_BITS > 0));
      assign mi = bus.approx_en;
      assign vi = bus.in_valid;
      assign sum_d = r[SW-1:0];
    end else begin : g_next
      assign xa = g_stage[s-1].g_ops.a_q[SW-1:0];
      assign xb = g_stage[s-1].g_ops.b_q[SW-1:0];
      assign ci = g_stage[s-1].c_q;
      assign mi = g_stage[s-1].m_q;
      assign vi = g_stage[s-1].v_q;
      assign sum_d = {r[SW-1:0], g_stage[s-1].sum_q};
    end

    assign r = seg_add(xa, xb, ci, mi, s * SW);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        m_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (!stall) begin
        v_q   <= vi;
        m_q   <= mi;
        c_q   <= r[SW];
        sum_q <= sum_d;
      end
    end

    // Operand bits not yet consumed ride along, shrinking per stage.
    if (s < SEGS - 1) begin : g_ops
      localparam int HW = WIDTH - (s + 1) * SW;
      logic [HW-1:0] a_q;
      logic [HW-1:0] b_q;
      logic [HW-1:0] a_d;
      logic [HW-1:0] b_d;

      if (s == 0) begin : g_src0
        assign a_d = bus.a[WIDTH-1:SW];
        assign b_d = bus.b[WIDTH-1:SW];
      end else begin : g_srcn
        assign a_d = g_stage[s-1].g_ops.a_q[HW+SW-1:SW];
        assign b_d = g_stage[s-1].g_ops.b_q[HW+SW-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign stall          = g_stage[SEGS-1].v_q & ~bus.out_ready;
  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = g_stage[SEGS-1].v_q;
  assign bus.sum        = g_stage[SEGS-1].sum_q;
  assign bus.cout       = g_stage[SEGS-1].c_q;
  assign bus.out_approx = g_stage[SEGS-1].m_q;
endmodule

// File: tb/tb_approx_carry_adder_pipe.sv
// Bench for approx_carry_adder_pipe: reference model, scoreboard,
// directed test-plan vectors, backpressure, reset and random traffic.
module tb_approx_carry_adder_pipe;
  localparam int W = 16;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  approx_carry_adder_pipe_if #(.WIDTH(W)) bus ();

  approx_carry_adder_pipe #(
    .WIDTH(W), .SEGS(4), .APPROX_BITS(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W:0] res;
    logic       m;
  } exp_t;

  exp_t q[$];

  function automatic logic [W:0] model(
    logic [W-1:0] a, logic [W-1:0] b, logic c, logic m
  );
    logic [W:0] up;
    logic [W-1:0] mask;
    if (!m) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    mask = (16'd1 << K) - 16'd1;
    up = {1'b0, a >> K} + {1'b0, b >> K} +
         {{W{1'b0}}, a[K-1] & b[K-1]};
    return (up << K) | {1'b0, (a | b) & mask};
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard / stall monitor, sampled on the falling edge.
  logic         held = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_cout;
  logic         h_apx;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_sum", {16'd0, bus.sum}, {16'd0, h_sum});
        chk("stall_cout", {31'd0, bus.cout}, {31'd0, h_cout});
        chk("stall_apx", {31'd0, bus.out_approx},
            {31'd0, h_apx});
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        held = 1'b1;
        h_sum = bus.sum;
        h_cout = bus.cout;
        h_apx = bus.out_approx;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_sum", {16'd0, bus.sum}, {16'd0, e.res[W-1:0]});
          chk("sb_cout", {31'd0, bus.cout}, {31'd0, e.res[W]});
          chk("sb_apx", {31'd0, bus.out_approx}, {31'd0, e.m});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.res = model(bus.a, bus.b, bus.cin, bus.approx_en);
        e.m = bus.approx_en;
        q.push_back(e);
      end
    end
  end

  task automatic drive(logic [W-1:0] a, logic [W-1:0] b,
                       logic c, logic m);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = c;
    bus.approx_en = m;
  endtask

  task automatic directed(string name, logic [W-1:0] a,
                          logic [W-1:0] b, logic c, logic m,
                          logic [W-1:0] es, logic ec);
    int n;
    @(posedge clk); #1;
    drive(a, b, c, m);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, 32'd3);
    chk({name, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({name, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({name, "_apx"}, {31'd0, bus.out_approx}, {31'd0, m});
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, q.size(), 32'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    logic acc;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b1;

    chk("m_carry", {15'd0, model(16'hFFFF, 16'h0001, 0, 0)},
        32'h10000);
    chk("m_mode", {15'd0, model(16'h00FF, 16'h0001, 0, 1)},
        32'h000FF);
    chk("m_cin", {15'd0, model(16'h1234, 16'h1111, 1, 1)},
        32'h02345);
    chk("m_cut", {15'd0, model(16'h0008, 16'h0008, 0, 1)},
        32'h00018);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_apx", {31'd0, bus.out_approx}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    directed("carry", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1);
    directed("ex_mode", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0);
    directed("ap_mode", 16'h00FF, 16'h0001, 0, 1, 16'h00FF, 0);
    directed("ex_cin", 16'h1234, 16'h1111, 1, 0, 16'h2346, 0);
    directed("ap_cin", 16'h1234, 16'h1111, 1, 1, 16'h2345, 0);
    directed("ap_cut", 16'h0008, 16'h0008, 0, 1, 16'h0018, 0);
    directed("ex_cut", 16'h0008, 16'h0008, 0, 0, 16'h0010, 0);
    drain("drain_directed");

    idx = 0;
    cyc = 0;
    @(posedge clk); #1;
    while (idx < 8 && cyc < 200) begin
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      drive(16'($urandom), 16'($urandom), 1'($urandom),
            idx[0]);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    chk("stream_issued", idx, 32'd8);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("drain_stream");

    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_sum", {16'd0, bus.sum}, 32'd0);
    @(posedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    directed("post_rst", 16'h7FFF, 16'h8000, 1, 0, 16'h0000, 1);
    drain("drain_rst");

    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        drive(16'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom));
      else
        bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain("drain_random");

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/approx_carry_adder_pipe.md
# approx_carry_adder_pipe

Parametrised, pipelined carry-chain adder for the approximate datapath. It generalises the single-bit carry cell to WIDTH bits, split into SEGS registered carry segments. A per-operation mode bit selects an approximate lower part of APPROX_BITS bits: lower-part OR with a cut carry chain. It sits between operand fetch and writeback in the ALU and carries a valid/ready handshake on both sides.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEGS.
- SEGS, 4: carry-chain segments, one per pipeline stage; latency = SEGS cycles; 1 ≤ SEGS ≤ WIDTH.
- APPROX_BITS, 8: width of the approximate lower part; 0 ≤ APPROX_BITS < WIDTH; 0 forces exact behaviour.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  adder can accept a beat.
- a, b  in  WIDTH each  operands, unsigned.
- cin  in  1  carry-in.
- approx_en  in  1  1 = approximate mode for this beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB.
- out_approx  out  1  approx_en that travelled with this result.

## Operation
- Beat accepted when in_valid & in_ready. a, b, cin and approx_en are captured together. The mode travels with the data, so consecutive beats may mix modes.
- Exact mode (approx_en=0 or APPROX_BITS=0): {cout,sum} = a + b + cin, full WIDTH+1-bit result.
- Approximate mode (approx_en=1, APPROX_BITS=K>0):
  - sum[K-1:0] = a[K-1:0] | b[K-1:0].
  - The carry into bit K is a[K-1] & b[K-1].
  - cin is ignored.
  - Bits K..WIDTH-1 are exact ripple-add with that carry; cout is the true carry-out of the upper part.
- The approximate boundary may fall anywhere, including inside a segment or across several segments. Each bit position chooses its cell from its own index and the beat's mode.
- Segment pipeline:
  - Stage s (0..SEGS-1) computes bits [s·W/SEGS +: W/SEGS] using the carry registered by stage s-1 (stage 0 uses cin, or 0 in approx mode).
  - Unprocessed operand bits and already-computed sum bits are delayed alongside, so the output word is coherent.
- Each stage holds a valid bit. Stall is global: stall = out_valid & ~out_ready. While stalled, no stage register changes, and in_ready = ~stall.
- Bubbles: a stage whose valid is 0 may be overwritten even when later stages are busy only if no stall. There is no bubble collapsing, which keeps the pipeline simple.

## Timing
- Reset (async assert, sync-safe deassert):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, out_approx=0.
  - Inputs are ignored while rst=1.
  - in_ready = 1 from the first edge after deassertion.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+SEGS-1 completes, i.e. it is visible in the cycle after edge N+SEGS-1. The output stage is the last segment register.
- Throughput: one beat per cycle with out_ready held high.
- Outputs are held stable while out_valid & ~out_ready. The result retires on the edge where out_valid & out_ready; a new beat may enter on the same edge.
- Reset mid-operation discards all in-flight beats; nothing is emitted after reset until new beats are accepted.
- Wrap-around: exact overflow wraps sum modulo 2^WIDTH with cout=1.

## Test plan
Use WIDTH=16, SEGS=4, APPROX_BITS=4, out_ready=1 unless stated.
- Carry across all segments, exact: a=0xFFFF, b=0x0001, cin=0, approx_en=0 -> sum=0x0000, cout=1, out_valid exactly 4 cycles after acceptance.
- Mode contrast: a=0x00FF, b=0x0001, cin=0 -> exact sum=0x0100, cout=0; approx sum=0x00FF, out_approx=1.
- cin handling: a=0x1234, b=0x1111, cin=1 -> exact 0x2346; approx 0x2345 (cin ignored).
- Cut-carry generation: a=0x0008, b=0x0008 -> approx 0x0018; exact 0x0010.
- Streaming with backpressure:
  - Issue 8 back-to-back beats alternating modes, with out_ready low for 3 cycles mid-stream.
  - Required: results in order and bit-exact against the model; no beat lost or duplicated; outputs stable during the stall; in_ready=0 throughout the stall.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0, sum=0 immediately (async); no stale result after release; the next beat emits after 4 cycles.
